fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Downstream drain stage for `sync_fifo`. Pops one word at a time from the FIFO read port when enabled and data is present, then serializes it as an asynchronous UART frame on `tx`: start bit, data LSB-first, optional even parity, one stop bit. It is the consumer that turns buffered bytes into a line-rate serial stream.

## Interface

- `WIDTH`, 8: data word width; matches the FIFO `WIDTH`.
- `CLKS_PER_BIT`, 16: `clk` cycles per serial bit; must be ≥ 2.
- `PARITY_EN`, 0: 1 inserts an even-parity bit after the data bits.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  allows a new frame to start; sampled only in IDLE.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_rdata`  in  WIDTH  FIFO read data; valid the cycle after `fifo_rd_en` is sampled high.
- `fifo_rd_en`  out  1  FIFO read strobe; high for one cycle per frame.
- `tx`  out  1  serial line output; idles high.
- `busy`  out  1  high in every state except IDLE.
- `tx_done`  out  1  one-cycle pulse on the final cycle of the stop bit.

## Operation

- State machine: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- **IDLE:**
  - `tx`=1.
  - If `en`=1 and `fifo_empty`=0, go to FETCH; otherwise remain in IDLE.
- **FETCH:**
  - `fifo_rd_en`=1 for exactly this cycle.
  - Always go to LOAD. `fifo_empty` is not rechecked.
- **LOAD:**
  - Capture `fifo_rdata` into the WIDTH-bit shift register.
  - Clear the baud counter and bit counter.
  - Go to START.
- **START:** `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- **DATA:**
  - `tx` = shift[0], LSB first.
  - After `CLKS_PER_BIT` cycles, shift right and increment the bit counter.
  - After WIDTH bits, go to PARITY if `PARITY_EN`=1, otherwise go to STOP.
- **PARITY:**
  - `tx` = XOR of the captured word (even parity).
  - Compute the XOR in LOAD from the captured word.
  - Hold for `CLKS_PER_BIT` cycles, then go to STOP.
- **STOP:**
  - `tx`=1 for `CLKS_PER_BIT` cycles.
  - `tx_done`=1 on the last of those cycles.
  - Go to IDLE.
- Counters:
  - Baud counter: `$clog2(CLKS_PER_BIT)` bits, counts 0..`CLKS_PER_BIT`-1, wraps to 0 at the bit boundary.
  - Bit counter: `$clog2(WIDTH)+1` bits.
- All outputs are registered. `tx`, `fifo_rd_en`, `busy` and `tx_done` change only on clock edges.
- Invariant: `fifo_rd_en` is never high while `fifo_empty`=1 was sampled in the preceding IDLE cycle. The FIFO `error` output therefore never asserts due to this block.
- `en` dropping mid-frame has no effect; the current frame completes and no new frame starts.
- `fifo_rdata` changes outside LOAD are ignored.

## Timing

- Reset values: `tx`=1, `fifo_rd_en`=0, `busy`=0, `tx_done`=0; state=IDLE; counters=0.
- Reset mid-frame:
  - Next cycle is IDLE with `tx`=1.
  - The popped word is discarded and is not re-read.
- Start-up sequence, where edge N is the first edge sampling `en`=1 and `fifo_empty`=0 in IDLE:
  - `fifo_rd_en` is high in cycle N+1.
  - `busy` rises at N+1.
  - `tx` falls at N+3.
- Frame length from the `tx` falling edge to the end of the stop bit: (2 + WIDTH + `PARITY_EN`) × `CLKS_PER_BIT` cycles.
- Back-to-back frames with a non-empty FIFO:
  - After the stop bit, `tx` stays high for 3 extra cycles (IDLE, FETCH, LOAD).
  - Frame period = (2+WIDTH+`PARITY_EN`)×`CLKS_PER_BIT` + 3.
- `fifo_empty` rising in any non-IDLE state is ignored until IDLE.

## Test plan

All scenarios use `CLKS_PER_BIT`=4 and WIDTH=8.

- **Reset idle:** hold `rst` 2 cycles with `fifo_empty`=1 → `tx`=1, `busy`=0, `fifo_rd_en`=0 for 50 cycles.
- **Single byte, `PARITY_EN`=0:** write 0xA5 to the FIFO, `en`=1.
  - One `fifo_rd_en` pulse.
  - `tx` bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles).
  - `tx_done` pulses once.
  - `tx` falls 3 cycles after the empty→non-empty sample.
- **Parity, `PARITY_EN`=1:** 0xA5 → parity bit 0. 0x07 → parity bit 1. Frame is 44 cycles.
- **Back-to-back drain:** fill the FIFO with 16 `$random` words, `en`=1.
  - Exactly 16 `fifo_rd_en` pulses.
  - Decoded bytes match the write order.
  - Inter-frame high gap is 3 cycles beyond the stop bit.
  - FIFO `error` never asserts.
- **Enable gating:** `en`=0 with 3 words queued → no reads. Raise `en` → all 3 drain. Drop `en` during frame 2 → frame 2 completes and frame 3 does not start.
- **Reset mid-frame:** assert `rst` during DATA bit 3 → next cycle `tx`=1, `busy`=0. With `en`=1 afterwards, the next FIFO word is sent and the interrupted word is not resent.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a sync_fifo read port: one pop per frame,
// start bit, LSB-first data, optional even parity, one stop bit.
module fifo_uart_tx #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             busy,
  output logic             tx_done
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = $clog2(WIDTH) + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  shift;
  logic              parity;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BIT_W-1:0]  bit_cnt;

  // Every output is loaded with the value it must show in the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      shift      <= '0;
      parity     <= 1'b0;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      fifo_rd_en <= 1'b0;
      tx_done    <= 1'b0;
      case (state)
        S_IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (en && !fifo_empty) begin
            state      <= S_FETCH;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          shift    <= fifo_rdata;
          parity   <= ^fifo_rdata;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          tx       <= 1'b0;
          state    <= S_START;
        end
        S_START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            tx       <= shift[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        S_DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            shift    <= shift >> 1;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                tx    <= parity;
                state <= S_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        S_PARITY: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        S_STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
            // Raised one edge early so the pulse lands on the last stop cycle.
            if (baud_cnt == BAUD_PRE) tx_done <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (parity off / on) fed by queue-model
// FIFOs, with a line monitor that decodes each serial frame independently.
module tb_fifo_uart_tx;

  localparam int C = 4;

  typedef struct {
    logic [10:0] raw;
    int          start;
    int          done;
    bit          bad;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       empty_w [2];
  logic [7:0] rdata   [2];
  logic       rd_w    [2];
  logic       tx_w    [2];
  logic       busy_w  [2];
  logic       done_w  [2];

  logic [7:0] mem [2][256];
  int wp [2] = '{0, 0};
  int rp [2] = '{0, 0};
  int rd_cnt [2] = '{0, 0};
  int err [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int cyc = 0;

  int mcnt [2] = '{-1, -1};
  logic [10:0] mbits [2];
  int mstart [2];
  int mdone [2];
  bit mbad [2];
  rec_t rec0 [$];
  rec_t rec1 [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign empty_w[0] = (wp[0] == rp[0]);
  assign empty_w[1] = (wp[1] == rp[1]);

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(C), .PARITY_EN(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(empty_w[0]), .fifo_rdata(rdata[0]),
    .fifo_rd_en(rd_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]));

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(C), .PARITY_EN(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(empty_w[1]), .fifo_rdata(rdata[1]),
    .fifo_rd_en(rd_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]));

  // FIFO read side: data appears the cycle after the strobe is sampled.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int ch = 0; ch < 2; ch++) begin
      if (rd_w[ch]) begin
        rd_cnt[ch] <= rd_cnt[ch] + 1;
        if (wp[ch] == rp[ch]) err[ch] <= err[ch] + 1;
        else begin
          rdata[ch] <= mem[ch][rp[ch] % 256];
          rp[ch]    <= rp[ch] + 1;
        end
      end
    end
  end

  // Line monitor: frame opens on a low line, each bit must hold steady C cycles.
  always @(negedge clk) begin : mon
    int b;
    int nb;
    rec_t r;
    for (int ch = 0; ch < 2; ch++) begin
      nb = (ch == 1) ? 11 : 10;
      if (done_w[ch] === 1'b1) done_cnt[ch] = done_cnt[ch] + 1;
      if (rst) mcnt[ch] = -1;
      else begin
        if (mcnt[ch] < 0 && tx_w[ch] === 1'b0) begin
          mcnt[ch] = 0; mstart[ch] = cyc; mdone[ch] = -1; mbits[ch] = '0; mbad[ch] = 1'b0;
        end
        if (mcnt[ch] >= 0) begin
          b = mcnt[ch] / C;
          if (mcnt[ch] % C == 0) mbits[ch][b] = tx_w[ch];
          else if (tx_w[ch] !== mbits[ch][b]) mbad[ch] = 1'b1;
          if (done_w[ch] === 1'b1) mdone[ch] = cyc;
          mcnt[ch] = mcnt[ch] + 1;
          if (mcnt[ch] == nb * C) begin
            r.raw = mbits[ch]; r.start = mstart[ch]; r.done = mdone[ch]; r.bad = mbad[ch];
            if (ch == 0) rec0.push_back(r); else rec1.push_back(r);
            mcnt[ch] = -1;
          end
        end
      end
    end
  end

  task automatic push(input int ch, input logic [7:0] d);
    mem[ch][wp[ch] % 256] = d;
    wp[ch] = wp[ch] + 1;
  endtask

  task automatic wait_recs(input int ch, input int n, input int limit, output bit ok);
    int sz;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      sz = (ch == 0) ? rec0.size() : rec1.size();
      if (sz >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    int bad [2];
    rst = 1'b1; en = 1'b0;
    repeat (2) @(negedge clk);
    for (int ch = 0; ch < 2; ch++) begin
      checks++;
      if ({tx_w[ch], busy_w[ch], rd_w[ch], done_w[ch]} !== 4'b1000) begin
        errors++;
        $display("FAIL reset_values ch%0d got tx/busy/rd/done=%b want 1000", ch,
                 {tx_w[ch], busy_w[ch], rd_w[ch], done_w[ch]});
      end
    end
    rst = 1'b0;
    bad = '{0, 0};
    repeat (50) begin
      @(negedge clk);
      for (int ch = 0; ch < 2; ch++)
        if (tx_w[ch] !== 1'b1 || busy_w[ch] !== 1'b0 || rd_w[ch] !== 1'b0) bad[ch]++;
    end
    for (int ch = 0; ch < 2; ch++) begin
      checks++;
      if (bad[ch] !== 0) begin
        errors++;
        $display("FAIL reset_idle ch%0d got %0d non-idle cycles want 0", ch, bad[ch]);
      end
    end
  endtask

  task automatic test_single;
    int p, n0, rd0, dn0;
    bit ok;
    rec_t r;
    en = 1'b1;
    @(negedge clk);
    n0 = rec0.size(); rd0 = rd_cnt[0]; dn0 = done_cnt[0];
    p = cyc;
    push(0, 8'hA5);
    @(negedge clk);
    checks++;
    if (rd_w[0] !== 1'b1 || busy_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_fetch got rd=%b busy=%b want 1 1", rd_w[0], busy_w[0]);
    end
    @(negedge clk);
    checks++;
    if (rd_w[0] !== 1'b0 || tx_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_load got rd=%b tx=%b want 0 1", rd_w[0], tx_w[0]);
    end
    wait_recs(0, n0 + 1, 100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_timeout got no frame want 1 frame");
    end else begin
      r = rec0[n0];
      checks++;
      if (r.raw !== 11'({1'b1, 8'hA5, 1'b0}) || r.bad) begin
        errors++;
        $display("FAIL single_bits got %b glitch=%0d want %b", r.raw, r.bad, 11'({1'b1, 8'hA5, 1'b0}));
      end
      checks++;
      if (r.start - p !== 3) begin
        errors++;
        $display("FAIL single_latency got %0d want 3", r.start - p);
      end
      checks++;
      if (r.done - r.start !== 10 * C - 1) begin
        errors++;
        $display("FAIL single_done_pos got %0d want %0d", r.done - r.start, 10 * C - 1);
      end
    end
    repeat (5) @(negedge clk);
    checks++;
    if (rd_cnt[0] - rd0 !== 1 || done_cnt[0] - dn0 !== 1 || busy_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_counts got rd=%0d done=%0d busy=%b want 1 1 0",
               rd_cnt[0] - rd0, done_cnt[0] - dn0, busy_w[0]);
    end
  endtask

  task automatic test_parity;
    logic [7:0] words [4];
    logic [7:0] d;
    logic p;
    int n0;
    bit ok;
    rec_t r;
    words[0] = 8'hA5; words[1] = 8'h07;
    words[2] = 8'($urandom); words[3] = 8'($urandom);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = words[i];
      p = ($countones(d) % 2) == 1;
      n0 = rec1.size();
      push(1, d);
      wait_recs(1, n0 + 1, 100, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL parity_timeout word %0d got no frame want 1 frame", i);
      end else begin
        r = rec1[n0];
        checks++;
        if (r.raw !== {1'b1, p, d, 1'b0} || r.bad) begin
          errors++;
          $display("FAIL parity_bits d=%h got %b glitch=%0d want %b", d, r.raw, r.bad, {1'b1, p, d, 1'b0});
        end
        checks++;
        if (r.done - r.start !== 11 * C - 1) begin
          errors++;
          $display("FAIL parity_len d=%h got %0d want %0d", d, r.done - r.start + 1, 11 * C);
        end
      end
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] words [16];
    int n0, rd0;
    bit ok;
    rec_t r, q;
    en = 1'b0;
    @(negedge clk);
    n0 = rec0.size(); rd0 = rd_cnt[0];
    for (int i = 0; i < 16; i++) begin
      words[i] = 8'($urandom);
      push(0, words[i]);
    end
    en = 1'b1;
    wait_recs(0, n0 + 16, 16 * 60, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_timeout got %0d frames want 16", rec0.size() - n0);
    end else begin
      for (int i = 0; i < 16; i++) begin
        r = rec0[n0 + i];
        checks++;
        if (r.raw !== 11'({1'b1, words[i], 1'b0}) || r.bad) begin
          errors++;
          $display("FAIL b2b_data frame %0d got %b want %b", i, r.raw, 11'({1'b1, words[i], 1'b0}));
        end
        if (i > 0) begin
          q = rec0[n0 + i - 1];
          checks++;
          if (r.start - q.done !== 4 || r.start - q.start !== 10 * C + 3) begin
            errors++;
            $display("FAIL b2b_gap frame %0d got gap=%0d period=%0d want 4 %0d",
                     i, r.start - q.done, r.start - q.start, 10 * C + 3);
          end
        end
      end
    end
    repeat (10) @(negedge clk);
    checks++;
    if (rd_cnt[0] - rd0 !== 16 || err[0] !== 0) begin
      errors++;
      $display("FAIL b2b_reads got rd=%0d err=%0d want 16 0", rd_cnt[0] - rd0, err[0]);
    end
  endtask

  task automatic test_enable;
    logic [7:0] words [3];
    int n0, rd0;
    bit ok;
    en = 1'b0;
    @(negedge clk);
    n0 = rec0.size(); rd0 = rd_cnt[0];
    for (int i = 0; i < 3; i++) begin
      words[i] = 8'($urandom);
      push(0, words[i]);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (rd_cnt[0] - rd0 !== 0 || busy_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL enable_gate got rd=%0d busy=%b want 0 0", rd_cnt[0] - rd0, busy_w[0]);
    end
    en = 1'b1;
    wait_recs(0, n0 + 1, 100, ok);
    for (int i = 0; i < 20 && mcnt[0] < 0; i++) @(negedge clk);
    checks++;
    if (!ok || mcnt[0] < 0) begin
      errors++;
      $display("FAIL enable_frame2 got ok=%0d mcnt=%0d want frame 2 in progress", ok, mcnt[0]);
    end
    en = 1'b0;
    wait_recs(0, n0 + 2, 100, ok);
    repeat (60) @(negedge clk);
    checks++;
    if (rec0.size() - n0 !== 2 || rd_cnt[0] - rd0 !== 2) begin
      errors++;
      $display("FAIL enable_stop got frames=%0d rd=%0d want 2 2", rec0.size() - n0, rd_cnt[0] - rd0);
    end
    en = 1'b1;
    wait_recs(0, n0 + 3, 100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL enable_resume got %0d frames want 3", rec0.size() - n0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rec0[n0 + i].raw !== 11'({1'b1, words[i], 1'b0})) begin
          errors++;
          $display("FAIL enable_data frame %0d got %b want %b", i, rec0[n0 + i].raw,
                   11'({1'b1, words[i], 1'b0}));
        end
      end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [7:0] x, y;
    int n0, rd0;
    bit ok;
    en = 1'b0;
    @(negedge clk);
    n0 = rec0.size(); rd0 = rd_cnt[0];
    x = 8'($urandom); y = 8'($urandom);
    push(0, x); push(0, y);
    en = 1'b1;
    for (int i = 0; i < 100 && mcnt[0] < 4 * C; i++) @(negedge clk);
    checks++;
    if (mcnt[0] < 4 * C) begin
      errors++;
      $display("FAIL rstmid_reach got mcnt=%0d want >=%0d", mcnt[0], 4 * C);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || rd_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle got tx=%b busy=%b rd=%b want 1 0 0", tx_w[0], busy_w[0], rd_w[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_recs(0, n0 + 1, 100, ok);
    checks++;
    if (!ok || rec0[n0].raw !== 11'({1'b1, y, 1'b0})) begin
      errors++;
      $display("FAIL rstmid_next got ok=%0d raw=%b want %b", ok, ok ? rec0[n0].raw : 11'h0,
               11'({1'b1, y, 1'b0}));
    end
    repeat (60) @(negedge clk);
    checks++;
    if (rec0.size() - n0 !== 1 || rd_cnt[0] - rd0 !== 2 || wp[0] !== rp[0]) begin
      errors++;
      $display("FAIL rstmid_noresend got frames=%0d rd=%0d left=%0d want 1 2 0",
               rec0.size() - n0, rd_cnt[0] - rd0, wp[0] - rp[0]);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_parity;
    test_back_to_back;
    test_enable;
    test_reset_mid;
    checks++;
    if (err[0] !== 0 || err[1] !== 0) begin
      errors++;
      $display("FAIL fifo_error got %0d/%0d underflow reads want 0/0", err[0], err[1]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
